id_ex_stage: RTL and testbench

- Decode-to-execute pipeline register for the RISC-V pipeline core. It sits directly downstream of the immediate sign-extender and register file, and captures the extended immediate, both register operands, the PCs, register indices and the control bundle.
- It is built as a 2-entry skid buffer with valid/ready on both sides, so an execute-side stall never creates a combinational ready path back into decode.
- A synchronous flush supports branch/jump redirect.

---
 rtl/riscv_pkg.sv | 29 ++
 rtl/pipe_skid_reg.sv | 55 +++++
 rtl/id_ex_stage.sv | 72 +++++++
 tb/tb_id_ex_stage.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared types for the RISC-V pipeline core
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int CTRL_W = 10;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       alu_src;
    logic [2:0] alu_control;
  } ctrl_t;

  typedef struct packed {
    logic [XLEN-1:0] imm_ext;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    ctrl_t           ctrl;
  } id_ex_t;

endpackage

// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - generic 2-entry skid buffer with registered in_ready
module pipe_skid_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_valid;
  logic         skid_valid;
  logic [W-1:0] main_data;
  logic [W-1:0] skid_data;
  logic         in_fire;
  logic         out_fire;

  // in_ready depends only on a flop, so a stalled execute side never
  // reaches back into decode combinationally.
  assign in_ready  = !skid_valid;
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = main_valid && out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid || out_fire) begin
      main_valid <= skid_valid || in_fire;
      if (skid_valid) begin
        main_data  <= skid_data;
        skid_valid <= 1'b0;
      end else if (in_fire) begin
        main_data <= in_data;
      end
    end else if (in_fire) begin
      // main is held by a stalled consumer: park the new entry in skid
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - decode-to-execute pipeline register built on a skid buffer
module id_ex_stage #(
  parameter int XLEN   = riscv_pkg::XLEN,
  parameter int CTRL_W = riscv_pkg::CTRL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   Imm_Ext_D,
  input  logic [XLEN-1:0]   RD1_D,
  input  logic [XLEN-1:0]   RD2_D,
  input  logic [XLEN-1:0]   PC_D,
  input  logic [XLEN-1:0]   PCPlus4_D,
  input  logic [4:0]        Rs1_D,
  input  logic [4:0]        Rs2_D,
  input  logic [4:0]        Rd_D,
  input  logic [CTRL_W-1:0] Ctrl_D,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   Imm_Ext_E,
  output logic [XLEN-1:0]   RD1_E,
  output logic [XLEN-1:0]   RD2_E,
  output logic [XLEN-1:0]   PC_E,
  output logic [XLEN-1:0]   PCPlus4_E,
  output logic [4:0]        Rs1_E,
  output logic [4:0]        Rs2_E,
  output logic [4:0]        Rd_E,
  output logic [CTRL_W-1:0] Ctrl_E
);

  import riscv_pkg::*;

  id_ex_t d_pkt;
  id_ex_t e_pkt;

  assign d_pkt.imm_ext  = Imm_Ext_D;
  assign d_pkt.rd1      = RD1_D;
  assign d_pkt.rd2      = RD2_D;
  assign d_pkt.pc       = PC_D;
  assign d_pkt.pc_plus4 = PCPlus4_D;
  assign d_pkt.rs1      = Rs1_D;
  assign d_pkt.rs2      = Rs2_D;
  assign d_pkt.rd       = Rd_D;
  assign d_pkt.ctrl     = ctrl_t'(Ctrl_D);

  pipe_skid_reg #(
    .W($bits(id_ex_t))
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (d_pkt),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (e_pkt)
  );

  assign Imm_Ext_E = e_pkt.imm_ext;
  assign RD1_E     = e_pkt.rd1;
  assign RD2_E     = e_pkt.rd2;
  assign PC_E      = e_pkt.pc;
  assign PCPlus4_E = e_pkt.pc_plus4;
  assign Rs1_E     = e_pkt.rs1;
  assign Rs2_E     = e_pkt.rs2;
  assign Rd_E      = e_pkt.rd;
  assign Ctrl_E    = e_pkt.ctrl;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard bench for id_ex_stage
module tb_id_ex_stage;
  import riscv_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [XLEN-1:0]   Imm_Ext_E, RD1_E, RD2_E, PC_E, PCPlus4_E;
  logic [4:0]        Rs1_E, Rs2_E, Rd_E;
  logic [CTRL_W-1:0] Ctrl_E;

  id_ex_t cur;
  id_ex_t got;
  id_ex_t exp_q[$];
  int     total = 0;
  int     bad = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .Imm_Ext_D(cur.imm_ext),
    .RD1_D    (cur.rd1),
    .RD2_D    (cur.rd2),
    .PC_D     (cur.pc),
    .PCPlus4_D(cur.pc_plus4),
    .Rs1_D    (cur.rs1),
    .Rs2_D    (cur.rs2),
    .Rd_D     (cur.rd),
    .Ctrl_D   (cur.ctrl),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Imm_Ext_E(Imm_Ext_E),
    .RD1_E    (RD1_E),
    .RD2_E    (RD2_E),
    .PC_E     (PC_E),
    .PCPlus4_E(PCPlus4_E),
    .Rs1_E    (Rs1_E),
    .Rs2_E    (Rs2_E),
    .Rd_E     (Rd_E),
    .Ctrl_E   (Ctrl_E)
  );

  always_comb begin
    got          = '0;
    got.imm_ext  = Imm_Ext_E;
    got.rd1      = RD1_E;
    got.rd2      = RD2_E;
    got.pc       = PC_E;
    got.pc_plus4 = PCPlus4_E;
    got.rs1      = Rs1_E;
    got.rs2      = Rs2_E;
    got.rd       = Rd_E;
    got.ctrl     = ctrl_t'(Ctrl_E);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic rand_payload();
    cur.imm_ext  = $urandom;
    cur.rd1      = $urandom;
    cur.rd2      = $urandom;
    cur.pc       = $urandom & 32'hFFFF_FFFC;
    cur.pc_plus4 = cur.pc + 32'd4;
    cur.rs1      = 5'($urandom);
    cur.rs2      = 5'($urandom);
    cur.rd       = 5'($urandom);
    cur.ctrl     = ctrl_t'(10'($urandom));
  endtask

  // One clock: record what decode handed over, and mirror flush/reset in the model.
  task automatic step();
    logic fire;
    @(negedge clk);
    fire = in_valid && in_ready && rst;
    @(posedge clk);
    if (!rst || flush) exp_q.delete();
    else if (fire) exp_q.push_back(cur);
    #1;
  endtask

  // Monitor: every accepted output must be the oldest outstanding entry.
  always @(negedge clk) begin
    if (rst && !flush && out_valid && out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL mon_unexpected: got pc=%0h rd=%0d with empty scoreboard", PC_E, Rd_E);
      end else begin
        id_ex_t e;
        e = exp_q.pop_front();
        if (got !== e) begin
          bad++;
          $display("FAIL mon_payload: got %h expected %h", got, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    rand_payload();
    cur.imm_ext = 32'hFFFFF800;
    in_valid    = 1'b1;
    out_ready   = 1'b1;
    step();
    step();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_ctrl_e", 64'(Ctrl_E), 64'd0);

    rst = 1'b1;
    step();
    chk("rst_rel_valid", 64'(out_valid), 64'd1);
    chk("rst_rel_imm", 64'(Imm_Ext_E), 64'hFFFFF800);
    in_valid = 1'b0;
    step();

    // Streaming, out_ready high
    for (int i = 0; i < 8; i++) begin
      rand_payload();
      cur.pc       = 32'(i * 4);
      cur.pc_plus4 = cur.pc + 32'd4;
      in_valid     = 1'b1;
      step();
      chk("stream_pc", 64'(PC_E), 64'(i * 4));
      chk("stream_in_ready", 64'(in_ready), 64'd1);
    end
    in_valid = 1'b0;
    step();
    chk("stream_empty", 64'(out_valid), 64'd0);

    // Skid fill under backpressure
    out_ready = 1'b0;
    rand_payload(); cur.rd = 5'd1; in_valid = 1'b1;
    step();
    chk("skid_ready_after_1", 64'(in_ready), 64'd1);
    rand_payload(); cur.rd = 5'd2;
    step();
    chk("skid_ready_after_2", 64'(in_ready), 64'd0);
    rand_payload(); cur.rd = 5'd3;
    step();
    step();
    chk("skid_held_rd", 64'(Rd_E), 64'd1);
    chk("skid_held_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    step();
    chk("skid_drain_rd2", 64'(Rd_E), 64'd2);
    chk("skid_drain_ready", 64'(in_ready), 64'd1);
    step();
    chk("skid_drain_rd3", 64'(Rd_E), 64'd3);
    in_valid = 1'b0;
    step();
    chk("skid_drain_empty", 64'(out_valid), 64'd0);

    // Flush with both entries full and decode still presenting
    out_ready = 1'b0;
    in_valid  = 1'b1;
    rand_payload(); step();
    rand_payload(); step();
    rand_payload();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_full_valid", 64'(out_valid), 64'd0);
    chk("flush_full_ready", 64'(in_ready), 64'd1);

    // Flush while an input actually fires: it must be dropped too
    rand_payload(); step();
    rand_payload();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_fire_valid", 64'(out_valid), 64'd0);
    rand_payload();
    cur.pc    = 32'h100;
    out_ready = 1'b1;
    step();
    chk("flush_next_pc", 64'(PC_E), 64'h100);
    chk("flush_next_valid", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
    step();

    // Backpressure hold
    out_ready = 1'b0;
    rand_payload();
    cur.ctrl = ctrl_t'(10'h2A5);
    cur.rd2  = 32'hDEADBEEF;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_ctrl", 64'(Ctrl_E), 64'h2A5);
      chk("hold_rd2", 64'(RD2_E), 64'hDEADBEEF);
    end

    // Retire and accept in the same cycle, skid empty
    rand_payload();
    cur.imm_ext = 32'h00000FFE;
    in_valid    = 1'b1;
    out_ready   = 1'b1;
    step();
    chk("simul_imm", 64'(Imm_Ext_E), 64'h00000FFE);
    chk("simul_skid_empty", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
    step();

    // Random traffic against the scoreboard
    for (int i = 0; i < 400; i++) begin
      rand_payload();
      in_valid  = ($urandom_range(3, 0) != 0);
      out_ready = ($urandom_range(2, 0) != 0);
      flush     = ($urandom_range(24, 0) == 0);
      step();
    end
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && (exp_q.size() != 0 || out_valid); i++) step();
    chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("drain_out_valid", 64'(out_valid), 64'd0);

    // Asynchronous reset mid-stream drops everything at once
    out_ready = 1'b0;
    in_valid  = 1'b1;
    rand_payload(); step();
    rand_payload(); step();
    #2 rst = 1'b0;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_ready", 64'(in_ready), 64'd1);
    chk("async_rst_ctrl", 64'(Ctrl_E), 64'd0);
    step();
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    chk("post_rst_valid", 64'(out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
